// File: rtl/fport_serializer.sv
// Parallel-to-serial shifter, MSB first, DIV clocks per bit; optional even parity bit via FPORT_SERIALIZER_PARITY_EN.
// Latency: accepted start puts MSB on tx one clock later; done pulses one clock after the last bit period.
// Backpressure: none; start is ignored while busy, and start in the done cycle is accepted back-to-back.
module fport_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);

`ifdef FPORT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [BW-1:0]    bitcnt, bitcnt_nx;
  logic [DW-1:0]    divcnt, divcnt_nx;
  logic             tx_nx, busy_nx, done_nx;
`ifdef FPORT_SERIALIZER_PARITY_EN
  logic             par, par_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      tx     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef FPORT_SERIALIZER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      divcnt <= divcnt_nx;
      tx     <= tx_nx;
      busy   <= busy_nx;
      done   <= done_nx;
`ifdef FPORT_SERIALIZER_PARITY_EN
      par    <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    divcnt_nx = divcnt;
    done_nx   = 1'b0;
`ifdef FPORT_SERIALIZER_PARITY_EN
    par_nx    = par;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = SHIFT;
          shreg_nx  = data;
          bitcnt_nx = BIT_FIRST;
          divcnt_nx = '0;
`ifdef FPORT_SERIALIZER_PARITY_EN
          par_nx    = ^data;
`endif
        end
      end
      SHIFT: begin
        if (divcnt == DIV_LAST) begin
          divcnt_nx = '0;
          if (bitcnt != '0) begin
            shreg_nx  = shreg << 1;
            bitcnt_nx = bitcnt - BW'(1);
          end else begin
`ifdef FPORT_SERIALIZER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = IDLE;
            done_nx  = 1'b1;
`endif
          end
        end else begin
          divcnt_nx = divcnt + DW'(1);
        end
      end
`ifdef FPORT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (divcnt == DIV_LAST) begin
          divcnt_nx = '0;
          state_nx  = IDLE;
          done_nx   = 1'b1;
        end else begin
          divcnt_nx = divcnt + DW'(1);
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so tx/busy change on the same edge as the state.
  always_comb begin
    busy_nx = (state_nx != IDLE);
    tx_nx   = 1'b0;
    if (state_nx == SHIFT) tx_nx = shreg_nx[WIDTH-1];
`ifdef FPORT_SERIALIZER_PARITY_EN
    if (state_nx == PARITY) tx_nx = par_nx;
`endif
  end

endmodule
